// File: rtl/console_uart_tx.sv
// Console byte sink for bbq: buffers writes in a small FIFO and sends each byte as 8N1, LSB first.
// Overflowing writes are dropped and counted; the writer is never stalled.
module console_uart_tx #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            console_we,
  input  logic [XLEN-1:0] console_wdata,
  output logic            tx,
  output logic            busy,
  output logic            fifo_full,
  output logic [7:0]      drop_count
);

  localparam int unsigned BW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNTW = PW + 1;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [7:0]      drop_q, drop_d;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic full, push, pop, baud_last;

  // Only the low byte is transmitted.
  logic unused_wdata;
  assign unused_wdata = ^console_wdata[XLEN-1:8];

  always_comb begin
    full      = (count_q == CNTW'(FIFO_DEPTH));
    push      = console_we && !full;
    pop       = (state_q == StIdle) && (count_q != '0);
    baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));

    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase

    drop_d = (console_we && full && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;

    state_d = state_q;
    baud_d  = baud_q + BW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;

    case (state_q)
      StIdle: begin
        baud_d = '0;
        if (pop) begin
          state_d = StStart;
          shift_d = mem_q[rd_ptr_q];
          tx_d    = 1'b0;
        end
      end
      StStart: begin
        if (baud_last) begin
          state_d = StData;
          baud_d  = '0;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end
      end
      StData: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shift_q[bit_q + 3'd1];
          end
        end
      end
      StStop: begin
        if (baud_last) begin
          state_d = StIdle;
          baud_d  = '0;
        end
      end
      default: begin
        state_d = StIdle;
        baud_d  = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      baud_q   <= '0;
      bit_q    <= 3'd0;
      shift_q  <= 8'd0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= console_wdata[7:0];
    end
  end

  assign tx         = tx_q;
  assign busy       = (count_q != '0) || (state_q != StIdle);
  assign fifo_full  = full;
  assign drop_count = drop_q;

endmodule
